// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS core with 20-bit instructions:
// instruction field positions, opcodes of interest and the hazard FSM states.
package mips_pkg;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;

  localparam logic [4:0]  OP_JMP = 5'b10100;
  localparam logic [4:0]  OP_LD  = 5'b10001;
  localparam logic [4:0]  OP_HLT = 5'b11110;
  localparam logic [19:0] NOP    = 20'h00000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_JMP_WAIT = 2'd1,
    ST_LD_CHK   = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  function automatic logic [4:0] op_of(input logic [19:0] ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [2:0] rd_of(input logic [19:0] ins);
    return ins[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [2:0] rs_of(input logic [19:0] ins);
    return ins[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [2:0] rt_of(input logic [19:0] ins);
    return ins[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/pipe_hazard_decode.sv
// Combinational decode of the fetched instruction: control-flow opcodes and
// the load-use dependency against the destination of the preceding LD.
module pipe_hazard_decode
  import mips_pkg::*;
(
  input  logic [19:0] ins_pm,
  input  logic [2:0]  ld_rd,
  output logic        is_jmp,
  output logic        is_ld,
  output logic        is_hlt,
  output logic        ld_hazard
);

  logic unused_bits;

  assign is_jmp    = (op_of(ins_pm) == OP_JMP);
  assign is_ld     = (op_of(ins_pm) == OP_LD);
  assign is_hlt    = (op_of(ins_pm) == OP_HLT);
  // Both source fields are compared regardless of opcode; a false hit only costs a bubble.
  assign ld_hazard = (rs_of(ins_pm) == ld_rd) || (rt_of(ins_pm) == ld_rd);

  assign unused_bits = ^{ins_pm[RD_MSB:RD_LSB], ins_pm[5:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: jump bubbles, load-use interlock, halt and
// external memory hold, plus a saturating count of stall cycles.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int JMP_BUBBLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [19:0]      ins_pm,
  input  logic             ext_hold,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_ld_jmp,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] BUB_INIT = 2'(JMP_BUBBLES - 1);

  state_t           state_reg, state_next;
  logic [1:0]       bub_cnt_reg, bub_cnt_next;
  logic [2:0]       ld_rd_reg, ld_rd_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             is_jmp, is_ld, is_hlt, ld_hazard;
  logic             run_decode;
  logic             stall_inc;

  pipe_hazard_decode u_decode (
    .ins_pm    (ins_pm),
    .ld_rd     (ld_rd_reg),
    .is_jmp    (is_jmp),
    .is_ld     (is_ld),
    .is_hlt    (is_hlt),
    .ld_hazard (ld_hazard)
  );

  always_comb begin
    state_next   = state_reg;
    bub_cnt_next = bub_cnt_reg;
    ld_rd_next   = ld_rd_reg;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    pc_ld_jmp    = 1'b0;
    halted       = 1'b0;
    run_decode   = 1'b0;

    if (!reset) begin
      // Present RUN-idle strobes while reset is held, whatever is on ins_pm.
    end else if (state_reg == ST_HALT) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      halted     = 1'b1;
    end else if (ext_hold) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else begin
      case (state_reg)
        ST_JMP_WAIT: begin
          ifid_flush = 1'b1;
          if (bub_cnt_reg != 2'd0) begin
            pc_en        = 1'b0;
            bub_cnt_next = bub_cnt_reg - 2'd1;
          end else begin
            pc_ld_jmp  = 1'b1;
            state_next = ST_RUN;
          end
        end
        ST_LD_CHK: begin
          if (ld_hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_next = ST_RUN;
          end else begin
            run_decode = 1'b1;
          end
        end
        default: run_decode = 1'b1;
      endcase
    end

    if (run_decode) begin
      state_next = ST_RUN;
      if (is_jmp) begin
        state_next   = ST_JMP_WAIT;
        bub_cnt_next = BUB_INIT;
      end else if (is_ld) begin
        state_next = ST_LD_CHK;
        ld_rd_next = rd_of(ins_pm);
      end else if (is_hlt) begin
        // Keep the PC parked on the HLT and feed a NOP behind it.
        state_next = ST_HALT;
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  assign stall_inc = !pc_en && !ext_hold && (state_reg != ST_HALT);
  assign stall_cnt = stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_RUN;
      bub_cnt_reg   <= 2'd0;
      ld_rd_reg     <= 3'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bub_cnt_reg <= bub_cnt_next;
      ld_rd_reg   <= ld_rd_next;
      if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a bubble/interlock model of the pipeline controller.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int JB = 2;
  localparam logic [19:0] I_NOP = 20'h00000;
  localparam logic [19:0] I_JMP = 20'hA0000;
  localparam logic [19:0] I_HLT = 20'hF0000;
  localparam logic [19:0] I_LD2 = 20'h8A000;
  localparam logic [19:0] I_RS2 = 20'h00400;
  localparam logic [19:0] I_RS5 = 20'h00B40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ext_hold = 1'b0;
  logic [19:0] ins_pm = 20'h0;

  logic pc_en, ifid_en, ifid_flush, idex_flush, pc_ld_jmp, halted;
  logic [7:0] stall_cnt;
  logic pc_en4, ifid_en4, ifid_flush4, idex_flush4, pc_ld_jmp4, halted4;
  logic [3:0] stall_cnt4;

  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl #(.JMP_BUBBLES(JB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ins_pm(ins_pm), .ext_hold(ext_hold),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pc_ld_jmp(pc_ld_jmp), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.JMP_BUBBLES(JB), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ins_pm(ins_pm), .ext_hold(ext_hold),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
    .idex_flush(idex_flush4), .pc_ld_jmp(pc_ld_jmp4), .halted(halted4),
    .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  // Model: remaining NOP slots after a JMP, pending LD destination, halt flag, raw stall count.
  int m_bub = 0;
  bit m_ldp = 1'b0;
  int m_ldrd = 0;
  bit m_halt = 1'b0;
  int m_stalls = 0;

  typedef struct packed {
    logic pc_en, ifid_en, ifid_flush, idex_flush, pc_ld_jmp, halted;
  } exp_t;

  function automatic bit hazard_of(logic [19:0] ins);
    return m_ldp && ((int'(ins[11:9]) == m_ldrd) || (int'(ins[8:6]) == m_ldrd));
  endfunction

  function automatic exp_t model_out(logic [19:0] ins, logic hold, logic rst_n);
    exp_t e;
    e = '0;
    e.pc_en = 1'b1;
    e.ifid_en = 1'b1;
    if (!rst_n) return e;
    if (m_halt) begin
      e.pc_en = 0; e.ifid_en = 0; e.ifid_flush = 1; e.halted = 1;
    end else if (hold) begin
      e.pc_en = 0; e.ifid_en = 0;
    end else if (m_bub > 0) begin
      e.ifid_flush = 1;
      e.pc_en = (m_bub == 1);
      e.pc_ld_jmp = (m_bub == 1);
    end else if (hazard_of(ins)) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_flush = 1;
    end else if (ins[19:15] == 5'b11110) begin
      e.pc_en = 0; e.ifid_flush = 1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    exp_t e;
    if (!reset) begin
      m_bub <= 0; m_ldp <= 0; m_ldrd <= 0; m_halt <= 0; m_stalls <= 0;
    end else begin
      e = model_out(ins_pm, ext_hold, 1'b1);
      if (!m_halt && !ext_hold) begin
        if (!e.pc_en) m_stalls <= m_stalls + 1;
        if (m_bub > 0) m_bub <= m_bub - 1;
        else if (hazard_of(ins_pm)) m_ldp <= 0;
        else begin
          m_ldp <= 0;
          case (ins_pm[19:15])
            5'b10100: m_bub <= JB;
            5'b10001: begin m_ldp <= 1; m_ldrd <= int'(ins_pm[14:12]); end
            5'b11110: m_halt <= 1;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t e;
    e = model_out(ins_pm, ext_hold, reset);
    chk("pc_en", 32'(pc_en), 32'(e.pc_en));
    chk("ifid_en", 32'(ifid_en), 32'(e.ifid_en));
    chk("ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
    chk("idex_flush", 32'(idex_flush), 32'(e.idex_flush));
    chk("pc_ld_jmp", 32'(pc_ld_jmp), 32'(e.pc_ld_jmp));
    chk("halted", 32'(halted), 32'(e.halted));
    chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_stalls, 255)));
    chk("ctrl4", 32'({pc_en4, ifid_en4, ifid_flush4, idex_flush4, pc_ld_jmp4, halted4}), 32'(e));
    chk("stall_cnt4", 32'(stall_cnt4), 32'(sat(m_stalls, 15)));
  end

  task automatic cyc(input logic [19:0] ins, input logic hold);
    @(posedge clk); #1;
    ins_pm = ins;
    ext_hold = hold;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0; ins_pm = I_NOP; ext_hold = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  function automatic logic [19:0] rand_ins();
    int k;
    logic [4:0] op;
    k = $urandom_range(0, 29);
    if (k < 5) op = 5'b10100;
    else if (k < 12) op = 5'b10001;
    else if (k == 12) op = 5'b11110;
    else op = 5'($urandom);
    return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 6'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (20) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_pc_en", 32'(pc_en), 1);
    chk("rst_ifid_en", 32'(ifid_en), 1);
    chk("rst_flushes", 32'({ifid_flush, idex_flush, pc_ld_jmp}), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_halted", 32'(halted), 0);

    // JMP: one stalled bubble, then load with the second bubble
    cyc(I_JMP, 0); chk("jmp_fetch_pc", 32'(pc_en), 1);
    cyc(I_NOP, 0); chk("jmp_b1", 32'({pc_en, ifid_flush, pc_ld_jmp}), 32'b010);
    cyc(I_NOP, 0); chk("jmp_b2", 32'({pc_en, ifid_flush, pc_ld_jmp}), 32'b111);
    cyc(I_NOP, 0); chk("jmp_run", 32'({pc_en, ifid_flush, pc_ld_jmp}), 32'b100);
    chk("jmp_stall", 32'(stall_cnt), 1);

    // Load-use with rs=2, then a non-dependent follower
    do_reset();
    cyc(I_LD2, 0);
    cyc(I_RS2, 0); chk("lu_bubble", 32'({pc_en, ifid_en, idex_flush}), 32'b001);
    cyc(I_RS2, 0); chk("lu_resume", 32'({pc_en, ifid_en, idex_flush}), 32'b110);
    chk("lu_stall", 32'(stall_cnt), 1);
    do_reset();
    cyc(I_LD2, 0);
    cyc(I_RS5, 0); chk("nolu", 32'({pc_en, ifid_en, idex_flush}), 32'b110);
    chk("nolu_stall", 32'(stall_cnt), 0);

    // HLT: sticky across hold and jumps, cleared asynchronously by reset
    do_reset();
    cyc(I_HLT, 0); chk("hlt_detect", 32'({pc_en, ifid_flush, halted}), 32'b010);
    for (int i = 0; i < 10; i++) begin
      cyc(I_JMP, 1'(i));
      chk("hlt_hold", 32'({pc_en, ifid_en, ifid_flush, pc_ld_jmp, halted}), 32'b00101);
    end
    chk("hlt_stall", 32'(stall_cnt), 1);
    #2 reset = 0;
    #1 chk("hlt_async_rst", 32'({halted, pc_en}), 32'b01);
    @(posedge clk); #1 reset = 1;

    // ext_hold for 3 cycles inside the bubble window
    cyc(I_JMP, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(I_NOP, 1);
      chk("hold_frz", 32'({pc_en, ifid_en, ifid_flush, pc_ld_jmp}), 0);
      chk("hold_stall", 32'(stall_cnt), 0);
    end
    cyc(I_NOP, 0); chk("hold_b1", 32'({pc_en, ifid_flush, pc_ld_jmp}), 32'b010);
    cyc(I_NOP, 0); chk("hold_b2", 32'({pc_en, ifid_flush, pc_ld_jmp}), 32'b111);
    cyc(I_NOP, 0); chk("hold_done", 32'({pc_ld_jmp, stall_cnt}), 1);

    // Saturation: 20 JMPs give 20 stall cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(I_JMP, 0); cyc(I_NOP, 0); cyc(I_NOP, 0);
    end
    cyc(I_NOP, 0);
    chk("sat4", 32'(stall_cnt4), 15);
    chk("sat8", 32'(stall_cnt), 20);

    // Reset in the middle of a bubble abandons the jump
    do_reset();
    cyc(I_JMP, 0);
    cyc(I_NOP, 0); chk("mid_b1", 32'(pc_en), 0);
    #2 reset = 0;
    #1 chk("mid_rst", 32'({pc_en, pc_ld_jmp}), 32'b10);
    @(posedge clk); @(posedge clk); #1 reset = 1;
    @(negedge clk); chk("mid_rel", 32'({pc_en, pc_ld_jmp, stall_cnt}), 32'h200);
    cyc(I_NOP, 0); chk("mid_run", 32'({pc_en, ifid_flush, pc_ld_jmp}), 32'b100);

    // Randomized traffic with occasional hold and reset
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!reset) reset = ($urandom_range(0, 2) == 0);
      else if ((m_halt && $urandom_range(0, 4) == 0) || $urandom_range(0, 150) == 0) reset = 0;
      ext_hold = ($urandom_range(0, 6) == 0);
      ins_pm = rand_ins();
    end
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 8-bit MIPS core with 20-bit instructions.
- Decodes the instruction leaving program memory (ins_pm) and drives PC enable, IF/ID enable, bubble-injection and jump-load strobes.
- Covers jump bubbles, load-use interlock, halt and external memory hold.
- Sits between program memory/PC and the IF/ID and ID/EX pipeline registers; supersedes the single stall/stall_pm pair with per-stage controls and a stall-cycle counter.

Parameters:
- JMP_BUBBLES, 2, number of NOP cycles inserted after a fetched JMP (legal 1..3).
- CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ins_pm  input  20  instruction currently output by program memory (IF stage).
- ext_hold  input  1  data-memory wait; freezes the pipeline.
- pc_en  output  1  PC may advance or load this cycle.
- ifid_en  output  1  IF/ID register captures ins_pm.
- ifid_flush  output  1  IF/ID loads NOP instead of ins_pm.
- idex_flush  output  1  ID/EX loads NOP (load-use bubble).
- pc_ld_jmp  output  1  PC loads jump target this cycle.
- halted  output  1  core halted.
- stall_cnt  output  CNT_W  saturating count of stall cycles since reset.

Behaviour:
- Instruction fields:
  - opcode = ins_pm[19:15], rd = [14:12], rs = [11:9], rt = [8:6].
  - JMP = 5'b10100, HLT = 5'b11110, LD = 5'b10001.
- States: RUN, JMP_WAIT, LD_CHK, HALT. Registered: state, bub_cnt (2 bits), ld_rd (3 bits), stall_cnt. All outputs are combinational from state, ins_pm and ext_hold.
- Reset (reset=0, asynchronous): state=RUN, bub_cnt=0, ld_rd=0, stall_cnt=0, halted=0. While in reset, outputs equal RUN-idle values: pc_en=1, ifid_en=1, all flushes 0, pc_ld_jmp=0.
- ext_hold=1 (highest priority except HALT):
  - pc_en=0, ifid_en=0, all flushes 0, pc_ld_jmp=0.
  - state, bub_cnt, ld_rd and stall_cnt are frozen.
- RUN:
  - Outputs: pc_en=1, ifid_en=1, flushes 0.
  - opcode JMP -> JMP_WAIT, bub_cnt=JMP_BUBBLES-1.
  - opcode LD -> LD_CHK, ld_rd<=rd.
  - opcode HLT -> HALT; this cycle pc_en=0 and ifid_flush=1, so the PC stays on the HLT.
  - Any other opcode stays in RUN.
- JMP_WAIT:
  - Outputs: ifid_flush=1, ifid_en=1.
  - bub_cnt!=0: pc_en=0; bub_cnt decrements.
  - bub_cnt==0: pc_en=1, pc_ld_jmp=1, next state RUN.
  - Total NOPs inserted = JMP_BUBBLES.
  - ins_pm is not decoded in this state.
- LD_CHK: hazard = (rs==ld_rd) or (rt==ld_rd).
  - Hazard: pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; next state RUN, where the held instruction is re-decoded.
  - No hazard: behave exactly as RUN for this cycle, including JMP/LD/HLT decode and transitions.
  - Back-to-back LD with dependency on the first: interlock first; the second LD is decoded in RUN on the next cycle.
- HALT:
  - Outputs: pc_en=0, ifid_en=0, ifid_flush=1, halted=1.
  - Ignores ext_hold and ins_pm. Exits only via reset.
- stall_cnt:
  - Increments on any rising edge where pc_en=0, ext_hold=0 and state!=HALT; the HLT detect cycle counts.
  - Saturates at 2^CNT_W-1.
- Reset mid-operation: returns immediately to RUN, bub_cnt=0, counter cleared, and any pending bubbles are abandoned.

Decomposition:
- Package mips_pkg:
  - opcode localparams (OP_JMP, OP_LD, OP_HLT).
  - field bit positions.
  - state encoding (2-bit enum).
  - NOP encoding 20'h00000.
- One sub-module is natural: pipe_hazard_decode. It is purely combinational, takes ins_pm and ld_rd, and returns is_jmp, is_ld, is_hlt and ld_hazard. The FSM and counters stay in the top module.

Test Plan:
- Reset release: assert reset=0 for 200 ns, then deassert with ins_pm=20'h00000 -> pc_en=1, ifid_en=1, flushes 0, stall_cnt=0, halted=0.
- JMP: ins_pm=20'hA0000 for one cycle, JMP_BUBBLES=2 -> next cycle pc_en=0, ifid_flush=1; following cycle pc_en=1, pc_ld_jmp=1, ifid_flush=1; then RUN, stall_cnt=1.
- Load-use: 20'h8A000 (LD rd=2), then 20'h00400 (rs=2) -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with rs=rt=5 -> no stall.
- HLT: ins_pm=20'hF0000 -> same cycle pc_en=0, ifid_flush=1. Next cycle halted=1, persisting across 10 cycles with ext_hold toggled and ins_pm=20'hA0000. Reset low -> halted=0 asynchronously.
- ext_hold during JMP_WAIT: hold for 3 cycles mid-bubble -> outputs frozen low, bub_cnt and stall_cnt unchanged. On release the bubble sequence resumes and completes with a single pc_ld_jmp pulse.
- Saturation with CNT_W=4: 20 consecutive JMPs -> stall_cnt stops at 15. Also assert reset mid-JMP_WAIT -> pc_ld_jmp is never asserted and state is RUN.
